// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake and instruction-RAM write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;
  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata, busy, done, err, cpu_hold
  );
  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, we, waddr, wdata, busy, done, err, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed byte stream into big-endian word writes to the instruction RAM,
// holding the CPU in reset until a complete program has landed.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NWORDS = 64
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;
  localparam logic [8:0] L_NMAX    = 9'(NWORDS);
  logic [2:0]        r_state;
  logic [7:0]        r_n;
  logic [ADDR_W-3:0] r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_shreg;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_ready;
  logic              w_acc;
  logic              w_last;
  logic              w_idle;
  assign w_ready = (r_state == S_LEN) || (r_state == S_COLLECT);
  assign w_acc   = bus.byte_valid && w_ready;
  assign w_last  = (r_n - 8'd1) == 8'(r_word_idx);
  assign w_idle  = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign bus.byte_ready = w_ready;
  assign bus.busy       = (r_state == S_LEN) || (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign bus.done       = r_state == S_DONE;
  assign bus.err        = r_state == S_ERR;
  assign bus.cpu_hold   = r_state != S_DONE;
  assign bus.we         = r_we;
  assign bus.waddr      = r_waddr;
  assign bus.wdata      = r_wdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_shreg    <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_idle && bus.start) begin
        r_state    <= S_LEN;
        r_word_idx <= '0;
        r_byte_idx <= '0;
      end else if (r_state == S_LEN && w_acc) begin
        r_n     <= bus.byte_data;
        r_state <= (bus.byte_data == 8'd0) ? S_DONE :
                   ({1'b0, bus.byte_data} > L_NMAX) ? S_ERR : S_COLLECT;
      end else if (r_state == S_COLLECT && w_acc) begin
        r_shreg    <= {r_shreg[15:0], bus.byte_data};
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          r_wdata <= {r_shreg, bus.byte_data};
          r_waddr <= {r_word_idx, 2'b00};
          r_we    <= 1'b1;
          r_state <= S_WRITE;
        end
      end else if (r_state == S_WRITE) begin
        r_word_idx <= r_word_idx + 1'b1;
        r_byte_idx <= '0;
        r_state    <= w_last ? S_DONE : S_COLLECT;
      end else if (r_state > S_ERR) begin
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives fixed and random programs into the loader and checks every RAM write,
// the completion flags and asynchronous reset against an expected-write list built from the program.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int NWORDS = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] prog [NWORDS];
  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];
  logic prev_we = 1'b0;
  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NWORDS(NWORDS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Record every write pulse and police its shape: single cycle, no byte consumed.
  always @(negedge clk) begin
    if (!reset && bus.we) begin
      q_addr.push_back(32'(bus.waddr));
      q_data.push_back(bus.wdata);
      check("we_single", 32'(prev_we), 32'd0);
      check("ready_in_write", 32'(bus.byte_ready), 32'd0);
    end
    prev_we <= bus.we;
  end
  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'(bus.byte_ready), 32'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic load(input logic [7:0] n, input int gap, input bit poke);
    int t = 0;
    int nw;
    bit ok;
    q_addr.delete();
    q_data.delete();
    ok = n <= NWORDS;
    nw = ok ? int'(n) : 0;
    pulse_start();
    send(n, gap);
    for (int i = 0; i < nw; i++)
      for (int b = 0; b < 4; b++) begin
        if (poke && i == 1 && b == 1) bus.start = 1'b1;
        send(prog[i][31-8*b -: 8], gap);
        bus.start = 1'b0;
      end
    while (!(bus.done || bus.err) && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("done", 32'(bus.done), 32'(ok));
    check("err", 32'(bus.err), 32'(!ok));
    check("cpu_hold", 32'(bus.cpu_hold), 32'(!ok));
    check("busy", 32'(bus.busy), 32'd0);
    check("n_writes", q_addr.size(), nw);
    for (int i = 0; i < nw && i < q_addr.size(); i++) begin
      check("waddr", q_addr[i], 32'(i * 4));
      check("wdata", q_data[i], prog[i]);
    end
  endtask
  task automatic rst_mid(input int nbytes);
    pulse_start();
    send(8'd3, 0);
    for (int k = 0; k < nbytes; k++) send(prog[k/4][31-8*(k%4) -: 8], 0);
    #1 reset = 1'b1;
    #1;
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hold", 32'(bus.cpu_hold), 32'd1);
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load(8'd3, 0, 1'b0);
  endtask
  task automatic set_demo();
    prog[0] = 32'h20020005;
    prog[1] = 32'h2003000c;
    prog[2] = 32'h2067fff7;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_state_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_state_we", 32'(bus.we), 32'd0);
    check("rst_state_waddr", 32'(bus.waddr), 32'd0);
    check("rst_state_wdata", bus.wdata, 32'd0);
    check("rst_state_busy", 32'(bus.busy), 32'd0);
    check("rst_state_done", 32'(bus.done), 32'd0);
    check("rst_state_err", 32'(bus.err), 32'd0);
    check("rst_state_hold", 32'(bus.cpu_hold), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    set_demo();
    load(8'd3, 0, 1'b0);
    load(8'd3, 3, 1'b0);
    load(8'd0, 0, 1'b0);
    load(8'd65, 0, 1'b0);
    prog[0] = 32'h08000012;
    load(8'd1, 0, 1'b0);
    for (int i = 0; i < NWORDS; i++) prog[i] = 32'h1000_0000 + i;
    load(8'd64, 0, 1'b0);
    check("last_waddr", q_addr[$], 32'h000000fc);
    check("last_wdata", q_data[$], 32'h1000003f);
    set_demo();
    rst_mid(6);
    rst_mid(4);
    load(8'd3, 1, 1'b1);
    for (int r = 0; r < 20; r++) begin
      logic [7:0] n;
      n = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 12));
      for (int i = 0; i < NWORDS; i++) prog[i] = $urandom;
      load(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction store. Accepts a byte stream (length header followed by instruction bytes) over a valid/ready handshake.
- Assembles big-endian 32-bit instruction words and drives the write port of the instruction RAM at word-aligned byte addresses.
- Holds the processor in reset until a complete program has been written.
- Sits between the host/UART byte source and the instruction RAM that the datapath fetches from.

Parameters:
- ADDR_W, 8, byte-address width of the instruction store (matches the fetch address width).
- DATA_W, 32, instruction word width; fixed at 32, 4 bytes per word.
- NWORDS, 64, capacity in words; must equal 2**(ADDR_W-2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready at a rising edge.
- we  output  1  instruction RAM write enable, one cycle per word.
- waddr  output  ADDR_W  byte address of the word being written; bits [1:0] always 0.
- wdata  output  DATA_W  assembled instruction word.
- busy  output  1  load in progress (LEN, COLLECT or WRITE).
- done  output  1  last load completed successfully.
- err  output  1  last load rejected (length out of range).
- cpu_hold  output  1  keep processor in reset; 0 only in DONE.

Behaviour:
- Reset (async, immediate): state=IDLE; byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, cpu_hold=1. A partially assembled word is discarded. Reset asserted mid-load deasserts we without waiting for a clock edge.
- Outputs we, waddr and wdata are registered. byte_ready, busy, done, err and cpu_hold are Moore decodes of state.
- IDLE:
  - byte_ready=0.
  - start -> LEN; word and byte counters cleared.
- LEN:
  - byte_ready=1; the accepted byte is N, the word count.
  - N==0 -> DONE, no writes.
  - N>NWORDS -> ERR.
  - Otherwise latch N -> COLLECT.
- COLLECT:
  - byte_ready=1. byte_idx runs 0..3.
  - Each accepted byte shifts in MSB-first: shreg <= {shreg[23:0], byte_data}.
  - On acceptance at byte_idx==3 -> WRITE, with wdata <= {shreg[23:0], byte_data} and waddr <= word_idx<<2.
- WRITE:
  - we=1 for exactly this one cycle; byte_ready=0, so any byte offered is not consumed.
  - Next cycle: word_idx+1. If word_idx==N-1 -> DONE, else -> COLLECT with byte_idx=0.
- DONE:
  - done=1, cpu_hold=0.
  - start -> LEN; done clears and cpu_hold reasserts.
- ERR:
  - err=1, cpu_hold=1.
  - start -> LEN; err clears.
- Latency and throughput:
  - 4th byte accepted at edge k -> we high during cycle k..k+1.
  - Minimum 5 cycles per word with a continuous stream.
  - byte_valid gaps stall without penalty; no timeout.
- start while busy is ignored. start is ignored in COLLECT, LEN and WRITE alike.
- waddr never exceeds (NWORDS-1)*4; word_idx cannot wrap because N<=NWORDS.
- Addresses not written in a load keep their previous RAM contents. The loader never clears the RAM.
- byte_valid with byte_ready=0 causes no state change.

Test Plan:
- Reset, start, stream 03 | 20 02 00 05 | 20 03 00 0c | 20 67 ff f7 back-to-back -> three single-cycle we pulses: (00,20020005), (04,2003000c), (08,2067fff7). Then done=1, cpu_hold=0, busy=0.
- Same program with byte_valid low for 3 cycles between every byte -> identical writes and addresses. we never high more than one cycle. byte_ready=0 during each WRITE cycle.
- Length byte 00 -> no we pulse, done=1 two cycles after start. Length byte 41 (65) -> no writes, err=1, cpu_hold=1. Then start plus a valid 01 | 08 00 00 12 load -> err=0, write (00,08000012), done=1.
- Full-capacity load, length 40 (64), word i = 32'h1000_0000+i -> 64 writes, last at waddr fc with wdata 1000003f, then DONE.
- Assert reset after 2 bytes of word 1 in a 3-word load -> we, busy and done drop to 0 immediately with cpu_hold=1. A new start plus a full stream writes from waddr 00 with no stale bytes in wdata.
- Pulse start while in COLLECT -> ignored; the load completes with the original count and addresses unchanged.
